// File: rtl/csr_timer_pkg.sv
// Shared CSR numbers, TCFG/TICLR field positions and helpers for the timer slice.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package csr_timer_pkg;

    // CSR numbers owned by the timer slice
    localparam logic [13:0] CSR_TID   = 14'h0040;
    localparam logic [13:0] CSR_TCFG  = 14'h0041;
    localparam logic [13:0] CSR_TVAL  = 14'h0042;
    localparam logic [13:0] CSR_TICLR = 14'h0044;

    // TCFG field positions; InitVal runs from CSR_TCFG_INITV_LSB up to TIMER_W-1
    localparam int CSR_TCFG_EN        = 0;
    localparam int CSR_TCFG_PERIOD    = 1;
    localparam int CSR_TCFG_INITV_LSB = 2;

    // TICLR clear-trigger bit
    localparam int CSR_TICLR_CLR = 0;

    // What TVAL does on the next edge
    typedef enum logic [1:0] {
        TV_HOLD = 2'd0,   // keep current value (disabled, idle, or frozen by write)
        TV_LOAD = 2'd1,   // load {InitVal, 2'b00}
        TV_IDLE = 2'd2,   // park at all-ones after a one-shot expiry
        TV_DEC  = 2'd3    // count down by one
    } tval_op_e;

    // Bitwise write-merge used by every writable timer CSR
    function automatic logic [31:0] masked_wr(input logic [31:0] old_val,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wvalue);
        return (wmask & wvalue) | (~wmask & old_val);
    endfunction

endpackage

// File: rtl/csr_timer_stable_cnt64.sv
// 64-bit free-running stable counter, +1 every cycle out of reset, wraps at 2^64.
// Latency: count visible one cycle after each edge; no input path.
// Backpressure: none; only compiled when CSR_TIMER_STABLE_CNT_EN is defined.
`ifdef CSR_TIMER_STABLE_CNT_EN
module stable_cnt64 (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // next count: plain increment, natural wrap
    always_comb begin
        cnt_d = cnt_q + 64'd1;
    end

    // counter register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/csr_timer.sv
// Constant-frequency timer CSR slice (TID/TCFG/TVAL/TICLR) plus optional stable counter (CSR_TIMER_STABLE_CNT_EN).
// Latency: reads combinational (zero cycles); writes and counting take effect on the next clk edge.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
module csr_timer #(
    parameter int          TIMER_W   = 32,
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic        csr_hit,
    output logic [31:0] csr_rvalue,
    output logic        timer_int,
    output logic [31:0] tid,
    output logic [63:0] stable_cnt
);

    import csr_timer_pkg::*;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_tid;
    logic sel_tcfg;
    logic sel_tval;
    logic sel_ticlr;

    assign sel_tid   = (csr_num == CSR_TID);
    assign sel_tcfg  = (csr_num == CSR_TCFG);
    assign sel_tval  = (csr_num == CSR_TVAL);
    assign sel_ticlr = (csr_num == CSR_TICLR);

    assign csr_hit = sel_tid | sel_tcfg | sel_tval | sel_ticlr;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [31:0]        tid_q,  tid_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               int_q,  int_d;

    logic     tcfg_wr;
    logic     en_q;
    logic     en_eff;
    logic     periodic_q;
    logic     tval_zero;
    logic     tval_ones;
    logic     irq_set;
    logic     irq_clr;
    tval_op_e tval_op;

    assign tcfg_wr    = csr_we & sel_tcfg;
    assign en_q       = tcfg_q[CSR_TCFG_EN];
    assign periodic_q = tcfg_q[CSR_TCFG_PERIOD];
    assign tval_zero  = (tval_q == '0);
    assign tval_ones  = &tval_q;

    // TID and TCFG next values: masked merge when addressed, otherwise hold
    always_comb begin
        tid_d  = tid_q;
        tcfg_d = tcfg_q;
        if (csr_we && sel_tid) begin
            tid_d = masked_wr(tid_q, csr_wmask, csr_wvalue);
        end
        if (tcfg_wr) begin
            tcfg_d = TIMER_W'(masked_wr(32'(tcfg_q), csr_wmask, csr_wvalue));
        end
    end

    // En as it will be after this cycle, so an enabling write sees tval==0 immediately
    assign en_eff = tcfg_d[CSR_TCFG_EN];

    // Choose the TVAL action; an enabling TCFG write beats counting, a disabling one freezes
    always_comb begin
        tval_op = TV_HOLD;
        if (tcfg_wr) begin
            if (en_eff) begin
                tval_op = TV_LOAD;
            end
        end else if (en_q) begin
            if (tval_zero) begin
                tval_op = periodic_q ? TV_LOAD : TV_IDLE;
            end else if (!tval_ones) begin
                tval_op = TV_DEC;
            end
        end
    end

    // Apply the selected TVAL action; reload always uses the post-write InitVal
    always_comb begin
        tval_d = tval_q;
        case (tval_op)
            TV_LOAD: tval_d = {tcfg_d[TIMER_W-1:CSR_TCFG_INITV_LSB], 2'b00};
            TV_IDLE: tval_d = '1;
            TV_DEC:  tval_d = tval_q - TIMER_W'(1);
            default: tval_d = tval_q;
        endcase
    end

    // Interrupt pending bit: set on an enabled zero, cleared by TICLR, set beats clear
    always_comb begin
        irq_set = en_eff & tval_zero;
        irq_clr = csr_we & sel_ticlr & csr_wmask[CSR_TICLR_CLR] & csr_wvalue[CSR_TICLR_CLR];
        int_d   = irq_set | (int_q & ~irq_clr);
    end

    // State registers, all returned to reset values asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tid_q  <= TID_RESET;
            tcfg_q <= '0;
            tval_q <= '1;
            int_q  <= 1'b0;
        end else begin
            tid_q  <= tid_d;
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            int_q  <= int_d;
        end
    end

    // Read mux: zero-latency, independent of csr_we; TICLR and misses read 0
    always_comb begin
        csr_rvalue = 32'h0;
        if (sel_tid) begin
            csr_rvalue = tid_q;
        end else if (sel_tcfg) begin
            csr_rvalue = 32'(tcfg_q);
        end else if (sel_tval) begin
            csr_rvalue = 32'(tval_q);
        end
    end

    assign timer_int = int_q;
    assign tid       = tid_q;

    // ------------------------------------------------------------------
    // Optional stable counter for rdcntvl.w / rdcntvh.w
    // ------------------------------------------------------------------
`ifdef CSR_TIMER_STABLE_CNT_EN
    stable_cnt64 u_stable_cnt64 (
        .clk   (clk),
        .rst   (rst),
        .cnt_o (stable_cnt)
    );
`else
    assign stable_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: vector tables plus hand-written countdown sequences.
// Latency: reads sampled at the negedge of the cycle they are driven in.
// Backpressure: n/a.
module tb_csr_timer;

    localparam logic [13:0] A_TID   = 14'h0040;
    localparam logic [13:0] A_TCFG  = 14'h0041;
    localparam logic [13:0] A_TVAL  = 14'h0042;
    localparam logic [13:0] A_TICLR = 14'h0044;
    localparam logic [31:0] ONES    = 32'hFFFF_FFFF;
    localparam logic [31:0] TIDRST  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csr_we = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic        csr_hit;
    logic [31:0] csr_rvalue;
    logic        timer_int;
    logic [31:0] tid;
    logic [63:0] stable_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        we;
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp_r;
        logic        exp_hit;
        logic        exp_int;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        hit;
        logic        irq;
        string       nm;
    } exp_t;

    exp_t sb_q[$];

    csr_timer #(.TIMER_W(32), .TID_RESET(TIDRST)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_we     (csr_we),
        .csr_num    (csr_num),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_hit    (csr_hit),
        .csr_rvalue (csr_rvalue),
        .timer_int  (timer_int),
        .tid        (tid),
        .stable_cnt (stable_cnt)
    );

    always #5 clk = ~clk;

    // bench-side count of clock edges seen out of reset
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [13:0] num,
                                 input logic [31:0] m, input logic [31:0] v,
                                 input logic [31:0] r, input logic h, input logic i,
                                 input string nm);
        vec_t x;
        x.we = we; x.num = num; x.mask = m; x.val = v;
        x.exp_r = r; x.exp_hit = h; x.exp_int = i; x.nm = nm;
        return x;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk({e.nm, "/rvalue"}, 64'(csr_rvalue), 64'(e.r));
            chk({e.nm, "/hit"},    64'(csr_hit),    64'(e.hit));
            chk({e.nm, "/int"},    64'(timer_int),  64'(e.irq));
        end
    endtask

    // drive one cycle, record the expectation, compare at the negedge
    task automatic apply(input vec_t v);
        exp_t e;
        csr_we     = v.we;
        csr_num    = v.num;
        csr_wmask  = v.mask;
        csr_wvalue = v.val;
        e.r = v.exp_r; e.hit = v.exp_hit; e.irq = v.exp_int; e.nm = v.nm;
        sb_q.push_back(e);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] r, input logic i, input string nm);
        apply(mkv(1'b0, num, 32'h0, 32'h0, r, 1'b1, i, nm));
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v,
                      input logic [31:0] r, input logic i, input string nm);
        apply(mkv(1'b1, num, m, v, r, 1'b1, i, nm));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];

        @(posedge clk);
        #1;

        // ---- reset values (reset held; writes must be ignored) ----
        tbl.push_back(mkv(0, A_TID,   0, 0, TIDRST, 1, 0, "rst_tid"));
        tbl.push_back(mkv(0, A_TCFG,  0, 0, 32'h0,  1, 0, "rst_tcfg"));
        tbl.push_back(mkv(0, A_TVAL,  0, 0, ONES,   1, 0, "rst_tval"));
        tbl.push_back(mkv(0, A_TICLR, 0, 0, 32'h0,  1, 0, "rst_ticlr"));
        tbl.push_back(mkv(0, 14'h05,  0, 0, 32'h0,  0, 0, "miss_num"));
        tbl.push_back(mkv(1, A_TID,   ONES, 32'h1234_5678, TIDRST, 1, 0, "rst_tid_wr"));
        tbl.push_back(mkv(0, A_TID,   0, 0, TIDRST, 1, 0, "rst_tid_hold"));
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);
        chk("rst_stable", stable_cnt, 64'h0);

        rst = 1'b1;

        // ---- masked writes ----
        tbl.delete();
        tbl.push_back(mkv(1, A_TID,   32'h0000_00FF, 32'h0000_ABCD, TIDRST, 1, 0, "tid_lo_wr"));
        tbl.push_back(mkv(0, A_TID,   0, 0, 32'h0000_00CD, 1, 0, "tid_lo_rb"));
        tbl.push_back(mkv(1, A_TID,   32'hFFFF_0000, 32'h5A5A_0000, 32'h0000_00CD, 1, 0, "tid_hi_wr"));
        tbl.push_back(mkv(0, A_TID,   0, 0, 32'h5A5A_00CD, 1, 0, "tid_hi_rb"));
        tbl.push_back(mkv(1, A_TCFG,  32'h0, ONES, 32'h0, 1, 0, "tcfg_mask0"));
        tbl.push_back(mkv(0, A_TCFG,  0, 0, 32'h0, 1, 0, "tcfg_mask0_rb"));
        tbl.push_back(mkv(1, A_TVAL,  ONES, 32'h1234, ONES, 1, 0, "tval_wr"));
        tbl.push_back(mkv(0, A_TVAL,  0, 0, ONES, 1, 0, "tval_ro"));
        tbl.push_back(mkv(1, A_TICLR, 32'h1, 32'h1, 32'h0, 1, 0, "ticlr_idle"));
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);
        chk("tid_port", 64'(tid), 64'h5A5A_00CD);

        // ---- one-shot, InitVal=4 ----
        wr(A_TCFG, ONES, 32'h11, 32'h0, 0, "os_cfg");
        for (int k = 0; k <= 16; k++) rd(A_TVAL, 32'h10 - 32'(k), 0, "os_cnt");
        rd(A_TVAL, ONES, 1, "os_fire");
        rd(A_TVAL, ONES, 1, "os_idle");
        rd(A_TCFG, 32'h11, 1, "os_cfg_rb");
        wr(A_TICLR, 32'hFFFF_FFFE, 32'h1, 32'h0, 1, "ticlr_nomask");
        wr(A_TICLR, 32'h1, 32'h1, 32'h0, 1, "ticlr_clr");
        rd(A_TVAL, ONES, 0, "irq_cleared");

        // ---- periodic, InitVal=2 ----
        wr(A_TCFG, ONES, 32'hB, 32'h11, 0, "per_cfg");
        for (int k = 0; k <= 8; k++) rd(A_TVAL, 32'h8 - 32'(k), 0, "per_cnt0");
        for (int k = 0; k <= 2; k++) rd(A_TVAL, 32'h8 - 32'(k), 1, "per_cnt1");
        wr(A_TICLR, 32'h1, 32'h1, 32'h0, 1, "per_clr");
        for (int k = 0; k <= 3; k++) rd(A_TVAL, 32'h4 - 32'(k), 0, "per_cnt2");
        wr(A_TICLR, 32'h1, 32'h1, 32'h0, 0, "setwins_wr");
        rd(A_TVAL, 32'h8, 1, "setwins");
        wr(A_TICLR, 32'h1, 32'h1, 32'h0, 1, "per_clr2");
        for (int k = 0; k <= 6; k++) rd(A_TVAL, 32'h6 - 32'(k), 0, "per_cnt3");
        rd(A_TVAL, 32'h8, 1, "per_reset");
        rd(A_TVAL, 32'h7, 1, "per_7");
        rd(A_TVAL, 32'h6, 1, "per_6");

        // ---- disable freezes tval ----
        wr(A_TCFG, 32'h1, 32'h0, 32'hB, 1, "freeze");
        rd(A_TVAL, 32'h5, 1, "frozen_a");
        rd(A_TVAL, 32'h5, 1, "frozen_b");
        rd(A_TCFG, 32'hA, 1, "cfg_en0");
        wr(A_TICLR, 32'h1, 32'h1, 32'h0, 1, "clr3");
        rd(A_TVAL, 32'h5, 0, "frozen_clr");

        // ---- one-shot InitVal=0 ----
        wr(A_TCFG, ONES, 32'h1, 32'hA, 0, "iv0_cfg");
        rd(A_TVAL, 32'h0, 0, "iv0_zero");
        rd(A_TVAL, ONES, 1, "iv0_fire");
        rd(A_TVAL, ONES, 1, "iv0_idle");

        // ---- enabling write while tval is already zero raises at once ----
        wr(A_TICLR, 32'h1, 32'h1, 32'h0, 1, "clr4");
        wr(A_TCFG, ONES, 32'h1, 32'h1, 0, "reload0");
        wr(A_TCFG, ONES, 32'h0, 32'h1, 0, "stop_at0");
        rd(A_TVAL, 32'h0, 0, "held0");
        wr(A_TCFG, ONES, 32'h5, 32'h0, 0, "en_at0");
        rd(A_TVAL, 32'h4, 1, "en_at0_irq");
        wr(A_TCFG, ONES, 32'hB, 32'h5, 1, "per_run");
        rd(A_TID, 32'h5A5A_00CD, 1, "tid_final");

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left actual=%0d expected=0", sb_q.size());
        end

        // ---- stable counter at 1000 cycles out of reset ----
        if (cyc > 1000) begin
            checks++;
            errors++;
            $display("FAIL stable_window actual=%0d expected=<=1000", cyc);
        end else begin
            while (cyc < 1000) @(negedge clk);
`ifdef CSR_TIMER_STABLE_CNT_EN
            chk("stable_1000", stable_cnt, 64'd1000);
`else
            chk("stable_off", stable_cnt, 64'd0);
`endif
        end

        // ---- asynchronous reset in the middle of periodic counting ----
        csr_num = A_TVAL;
        chk("pre_rst_irq", 64'(timer_int), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_tval", 64'(csr_rvalue), 64'(ONES));
        chk("mid_rst_irq",  64'(timer_int),  64'h0);
        chk("mid_rst_stable", stable_cnt, 64'h0);
        csr_num = A_TCFG;
        #1;
        chk("mid_rst_tcfg", 64'(csr_rvalue), 64'h0);
        csr_num = A_TID;
        #1;
        chk("mid_rst_tid", 64'(csr_rvalue), 64'(TIDRST));
        chk("mid_rst_tidport", 64'(tid), 64'(TIDRST));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
